// File: rtl/cache_trace_driver.sv
// cache_trace_driver: buffers host addresses in a FIFO and issues them one at a
// time to the cache simulator (trace_ready strobe, wait for updated or timeout).
// Optional stride generator enabled by defining TRACE_STRIDE_GEN_EN.
module cache_trace_driver #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TIMEOUT    = 1023,
    parameter int unsigned CNT_W      = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             wr_valid,
    input  logic [31:0]      wr_addr,
    output logic             wr_ready,
    output logic             trace_ready,
    output logic [31:0]      mem_addr,
    input  logic             updated,
    output logic             busy,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic [CNT_W-1:0] issued_count,
    output logic [CNT_W-1:0] done_count,
    output logic             err_timeout
`ifdef TRACE_STRIDE_GEN_EN
    ,
    input  logic             gen_start,
    input  logic [31:0]      gen_base,
    input  logic [31:0]      gen_stride,
    input  logic [15:0]      gen_len,
    output logic             gen_busy
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]   occ_q;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]   issued_q, issued_d, done_q, done_d;
    logic               err_q, err_d;
    logic               push, pop, push_host;
    logic [31:0]        push_data;

    assign fifo_empty   = (occ_q == '0);
    assign fifo_full    = (occ_q == OCC_W'(FIFO_DEPTH));
    assign wr_ready     = !fifo_full;
    assign push_host    = wr_valid && !fifo_full;
    assign trace_ready  = (state_q == ISSUE);
    assign busy         = (state_q != IDLE);
    assign mem_addr     = mem_addr_q;
    assign issued_count = issued_q;
    assign done_count   = done_q;
    assign err_timeout  = err_q;

`ifdef TRACE_STRIDE_GEN_EN
    logic        gen_busy_q;
    logic [31:0] gen_addr_q, gen_stride_q;
    logic [15:0] gen_left_q;
    logic        push_gen;

    assign gen_busy = gen_busy_q;
    // Generator only uses cycles the host leaves free.
    assign push_gen = gen_busy_q && !wr_valid && !fifo_full;

    // Stride generator: load on start, step address on each accepted push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gen_busy_q   <= 1'b0;
            gen_addr_q   <= '0;
            gen_stride_q <= '0;
            gen_left_q   <= '0;
        end else if (!gen_busy_q) begin
            if (gen_start && gen_len != 16'd0) begin
                gen_busy_q   <= 1'b1;
                gen_addr_q   <= gen_base;
                gen_stride_q <= gen_stride;
                gen_left_q   <= gen_len;
            end
        end else if (push_gen) begin
            gen_addr_q <= gen_addr_q + gen_stride_q;
            gen_left_q <= gen_left_q - 16'd1;
            if (gen_left_q == 16'd1) begin
                gen_busy_q <= 1'b0;
            end
        end
    end

    assign push      = push_host || push_gen;
    assign push_data = push_host ? wr_addr : gen_addr_q;
`else
    assign push      = push_host;
    assign push_data = wr_addr;
`endif

    // FIFO storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_data;
        end
    end

    // FIFO pointers and registered occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Issue FSM state, address, timer, counters and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            mem_addr_q <= '0;
            issued_q   <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            mem_addr_q <= mem_addr_d;
            issued_q   <= issued_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic. The head is popped and latched on entry to ISSUE so
    // mem_addr is already valid during the trace_ready strobe cycle.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        mem_addr_d = mem_addr_q;
        issued_d   = issued_q;
        done_d     = done_q;
        err_d      = err_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    pop        = 1'b1;
                    mem_addr_d = fifo_q[rd_ptr_q];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (issued_q != '1) issued_d = issued_q + 1'b1;
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (updated) begin
                    if (done_q != '1) done_d = done_q + 1'b1;
                    state_d = IDLE;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
